// File: rtl/chol_sqrt_if.sv
// Request/result bundle for the fixed-point square-root unit.
// The master drives a radicand; the slave returns the root after a fixed latency.
interface chol_sqrt_if #(
  parameter int unsigned WIDTH = 32
);
  logic             clken;
  logic             data_valid;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             neg_err;

  modport master (
    output clken,
    output data_valid,
    output data,
    input  busy,
    input  out,
    input  out_valid,
    input  neg_err
  );

  modport slave (
    input  clken,
    input  data_valid,
    input  data,
    output busy,
    output out,
    output out_valid,
    output neg_err
  );
endinterface

// File: rtl/chol_sqrt.sv
// Fixed-point square root by restoring digit recurrence: two radicand bits in,
// one root bit out per enabled cycle, MSB first, fixed latency of (WIDTH+FRAC)/2.
module chol_sqrt #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input logic        clk,
  input logic        rst,
  chol_sqrt_if.slave bus
);
  localparam int unsigned RadW = WIDTH + FRAC;
  localparam int unsigned N    = RadW / 2;
  localparam int unsigned RemW = N + 2;
  localparam int unsigned TmpW = RemW + 2;
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StCalc = 3'b010,
    StDone = 3'b100
  } state_e;

  state_e            state_q, state_d;
  logic [RadW-1:0]   rad_q, rad_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic [N-1:0]      root_q, root_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              neg_err_q, neg_err_d;

  logic [TmpW-1:0]   rem_shift;
  logic [TmpW-1:0]   trial;
  logic [RemW-1:0]   iter_rem;
  logic [N-1:0]      iter_root;
  logic              unused_bits;

  // One recurrence step; the remainder stays below 2^(N+1), so the top
  // bits of the widened temporaries only ever carry the trial sign.
  always_comb begin
    rem_shift = {rem_q, rad_q[RadW-1 -: 2]};
    trial     = rem_shift - {2'b00, root_q, 2'b01};
    if (trial[TmpW-1]) begin
      iter_rem  = rem_shift[RemW-1:0];
      iter_root = {root_q[N-2:0], 1'b0};
    end else begin
      iter_rem  = trial[RemW-1:0];
      iter_root = {root_q[N-2:0], 1'b1};
    end
  end

  assign unused_bits = ^{trial[TmpW-2:RemW], rem_shift[TmpW-1:RemW]};

  always_comb begin
    state_d     = state_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    busy_d      = busy_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    neg_err_d   = neg_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.data_valid) begin
          rad_d   = {1'b0, bus.data[WIDTH-2:0], {FRAC{1'b0}}};
          neg_d   = bus.data[WIDTH-1];
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        rad_d  = rad_q << 2;
        rem_d  = iter_rem;
        root_d = iter_root;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          out_d       = neg_q ? '0 : WIDTH'(iter_root);
          neg_err_d   = neg_q;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = StDone;
        end
      end
      StDone: begin
        out_valid_d = 1'b0;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      neg_err_q   <= 1'b0;
    end else if (bus.clken) begin
      state_q     <= state_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      neg_err_q   <= neg_err_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.neg_err   = neg_err_q;
endmodule

// File: tb/tb_chol_sqrt.sv
// Bench for chol_sqrt: fixed vectors, randomized radicands against an integer
// square-root model, and hand sequences for the busy, clken and reset corners.
module tb_chol_sqrt;
  localparam int unsigned Lat = 24;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  chol_sqrt_if #(.WIDTH(32)) bus ();

  chol_sqrt #(
    .WIDTH(32),
    .FRAC (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] exp_out;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Largest r with r*r <= x, found by binary search.
  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 24;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic model(input logic [31:0] d, output logic [31:0] o, output logic e);
    longint unsigned r;
    if (d[31]) begin
      o = '0;
      e = 1'b1;
    end else begin
      r = isqrt(longint'(d) << 16);
      o = r[31:0];
      e = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [31:0] d);
    bus.data       = d;
    bus.data_valid = 1'b1;
    bus.clken      = 1'b1;
    step();
    bus.data_valid = 1'b0;
    bus.data       = $urandom;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  // Returns with out_valid sampled high, or flags a timeout.
  task automatic wait_result(input bit rand_en, output int lat);
    int cycles;
    lat    = 0;
    cycles = 0;
    while (!bus.out_valid && cycles < 500) begin
      if (rand_en) bus.clken = 1'($urandom_range(0, 1));
      else         bus.clken = 1'b1;
      step();
      if (bus.clken) lat++;
      cycles++;
    end
    if (!bus.out_valid) check("result_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic finish_done();
    bus.clken = 1'b1;
    step();
    check("valid_pulse_end", 32'(bus.out_valid), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic run_and_check(input string name, input logic [31:0] d, input bit rand_en);
    logic [31:0] eo;
    logic        ee;
    int          lat;
    model(d, eo, ee);
    start_req(d);
    wait_result(rand_en, lat);
    check({name, "_out"}, bus.out, eo);
    check({name, "_err"}, 32'(bus.neg_err), 32'(ee));
    check({name, "_lat"}, 32'(lat), 32'(Lat));
  endtask

  initial begin
    vec_t        vecs[6];
    logic [31:0] d;
    logic [31:0] held;
    int          lat;
    bit          seen;

    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{32'h0004_0000, 32'h0002_0000, 1'b0};
    vecs[1] = '{32'h0001_0000, 32'h0001_0000, 1'b0};
    vecs[2] = '{32'h0000_0002, 32'h0000_016A, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h00B5_04F3, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0};

    rst            = 1'b1;
    bus.clken      = 1'b0;
    bus.data_valid = 1'b1;
    bus.data       = 32'h0004_0000;
    step();
    step();
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out", bus.out, 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_err", 32'(bus.neg_err), 32'd0);

    // Directed vectors; the first request lands on the first edge out of reset.
    for (int i = 0; i < 6; i++) begin
      start_req(vecs[i].data);
      wait_result(1'b0, lat);
      check("vec_out", bus.out, vecs[i].exp_out);
      check("vec_err", 32'(bus.neg_err), 32'(vecs[i].exp_err));
      check("vec_lat", 32'(lat), 32'(Lat));
      finish_done();
    end

    // Randomized radicands, half of them with a toggling clock enable.
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[31] = 1'b0;
      run_and_check("rand", d, 1'(i % 2));
      finish_done();
    end

    // Requests while busy and on the done edge are dropped.
    start_req(32'h0004_0000);
    bus.data_valid = 1'b1;
    bus.data       = 32'h0009_0000;
    repeat (5) step();
    bus.data_valid = 1'b0;
    wait_result(1'b0, lat);
    check("busy_ign_out", bus.out, 32'h0002_0000);
    check("busy_ign_lat", 32'(lat + 5), 32'(Lat));
    bus.data_valid = 1'b1;
    finish_done();
    bus.data_valid = 1'b0;
    step();
    check("done_no_accept", 32'(bus.busy), 32'd0);
    start_req(32'h0009_0000);
    check("out_held", bus.out, 32'h0002_0000);
    wait_result(1'b0, lat);
    check("after_done_out", bus.out, 32'h0003_0000);
    finish_done();

    // Gated clock: out_valid must hold while clken is low.
    run_and_check("clken", 32'h0004_0000, 1'b1);
    held      = bus.out;
    bus.clken = 1'b0;
    repeat (3) step();
    check("hold_valid", 32'(bus.out_valid), 32'd1);
    check("hold_out", bus.out, held);
    finish_done();

    // Reset mid-computation aborts with no result pulse.
    start_req(32'h0004_0000);
    repeat (10) step();
    rst       = 1'b1;
    bus.clken = 1'b0;
    step();
    rst       = 1'b0;
    bus.clken = 1'b1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_out", bus.out, 32'd0);
    check("abort_err", 32'(bus.neg_err), 32'd0);
    seen = 1'b0;
    repeat (30) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    run_and_check("post_abort", 32'h0001_0000, 1'b0);
    finish_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/chol_sqrt.md
CHOL_SQRT -- requirements
Module: chol_sqrt

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning total width of data and out in bits (signed Q format).
REQ-002 The block SHALL have parameter FRAC, default 16, meaning the number of fractional bits; WIDTH+FRAC SHALL be even, and only 32/16 is verified.
REQ-003 clk  input  1  clock; all registers update on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 clken  input  1  clock enable; when low, every register holds its value.
REQ-006 data_valid  input  1  request strobe; data is captured on an enabled edge when the block is idle.
REQ-007 data  input  WIDTH  radicand, signed Q(WIDTH-FRAC).FRAC.
REQ-008 busy  output  1  high from acceptance until the result edge.
REQ-009 out  output  WIDTH  square root, Q(WIDTH-FRAC).FRAC, unsigned value in a signed field.
REQ-010 out_valid  output  1  one-enabled-cycle pulse marking out and neg_err as valid.
REQ-011 neg_err  output  1  high with out_valid when the captured radicand was negative.

Function
REQ-012 out SHALL equal floor(sqrt(data * 2^FRAC)) for non-negative data, where data is the unsigned value of bits WIDTH-2:0.
REQ-013 The block SHALL compute with a restoring digit recurrence: each iteration consumes two radicand bits and produces one root bit, starting from the MSB.
REQ-014 The iteration count SHALL be N = (WIDTH+FRAC)/2, which is 24 at the default parameters.
REQ-015 The block SHALL use internal widths of WIDTH+FRAC bits for the radicand shift register, N+2 bits for the partial remainder and N bits for the root; no overflow is permitted.
REQ-016 The state machine SHALL have three states: S_IDLE, S_CALC and S_DONE, all one-hot encoded.
REQ-017 In S_IDLE, an enabled edge with data_valid=1 SHALL capture data, clear the remainder, root and iteration counter, set busy=1 and move to S_CALC.
REQ-018 In S_CALC, each enabled edge SHALL perform exactly one iteration and increment the counter.
REQ-019 On the enabled edge that completes iteration N, the block SHALL register out and neg_err, set out_valid=1, clear busy and move to S_DONE.
REQ-020 In S_DONE, the next enabled edge SHALL clear out_valid and return to S_IDLE; that edge SHALL NOT accept data_valid.
REQ-021 Latency SHALL be fixed: out_valid is high in the cycle following the N-th enabled edge after the acceptance edge.
REQ-022 Minimum request spacing SHALL be N+2 enabled edges.
REQ-023 data_valid asserted while busy=1 or in S_DONE SHALL be ignored, with no queuing and no effect on the running computation.
REQ-024 A negative radicand (data[WIDTH-1]=1) SHALL run the same latency, then produce out=0 and neg_err=1.
REQ-025 A non-negative radicand SHALL produce neg_err=0.
REQ-026 data=0 SHALL produce out=0 and neg_err=0 with the normal latency.
REQ-027 out and neg_err SHALL hold their last values until the next result edge; they are not cleared at acceptance.
REQ-028 With clken=0 the FSM, counter and outputs SHALL freeze; out_valid held high remains high until the next enabled edge.
REQ-029 data SHALL be sampled only at acceptance; changes to data afterwards SHALL NOT affect the result.

Reset
REQ-030 rst=1 SHALL take priority over clken and all other inputs.
REQ-031 Reset SHALL set state=S_IDLE, busy=0, out=0, out_valid=0, neg_err=0, and clear the counter, remainder and root.
REQ-032 Reset asserted mid-computation SHALL abort it with no out_valid pulse.
REQ-033 The first enabled edge after reset is released SHALL accept data_valid.

Verification
REQ-034 data=0x0004_0000 (4.0), clken=1 -> out=0x0002_0000, neg_err=0, out_valid one cycle, 24 cycles after acceptance.
REQ-035 data=0x0001_0000 -> out=0x0001_0000; data=0x0000_0002 -> out=0x0000_016A; data=0x7FFF_FFFF -> out=0x00B5_04F3.
REQ-036 data=0x8000_0000 -> out=0x0000_0000, neg_err=1 with out_valid; a following data=0 -> out=0, neg_err=0.
REQ-037 A second data_valid pulse with data=0x0009_0000 while busy -> ignored, result still 0x0002_0000 for the first request (4.0); a request issued after S_DONE -> 0x0003_0000.
REQ-038 clken toggled 1/0 pseudo-randomly during a 4.0 request -> the same result after exactly 24 enabled edges, with out_valid held high while clken=0.
REQ-039 rst pulsed at iteration 10 -> no out_valid, outputs zero, and the next request completes correctly.
